// File: rtl/iot_event_sequencer_if.sv
// Event-collection and replay bus of the IoT event sequencer.
// The master side feeds events and out_en; the slave side is the sequencer.
interface iot_event_sequencer_if #(
  parameter int N_CH = 4,
  parameter int CW   = 4
);
  logic [N_CH-1:0] ev_valid;
  logic [N_CH-1:0] ev_on;
  logic [N_CH-1:0] ev_ready;
  logic            out_en;
  logic            change;
  logic            on_off;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;

  modport master (
    output ev_valid, ev_on, out_en,
    input  ev_ready, change, on_off, fifo_count, fifo_full, fifo_empty
  );

  modport slave (
    input  ev_valid, ev_on, out_en,
    output ev_ready, change, on_off, fifo_count, fifo_full, fifo_empty
  );
endinterface

// File: rtl/iot_event_sequencer.sv
// Round-robin collector of device join/leave events, buffered in a FIFO and
// replayed as single-cycle change pulses for the active-device monitor.
module iot_event_sequencer #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  iot_event_sequencer_if.slave   bus
);
  localparam int PW = $clog2(N_CH);
  localparam int AW = $clog2(DEPTH);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   rr_next;
  logic [PW:0]     cand;
  logic            grant_any;
  logic [N_CH-1:0] ready;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // First valid channel at or above rr_ptr, wrapping modulo N_CH.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    ready     = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_CH)) cand = cand - (PW+1)'(N_CH);
      if (!grant_any && bus.ev_valid[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    // A full FIFO refuses pushes regardless of a same-cycle pop; nothing is
    // granted while reset is held.
    if (rst && !full && grant_any) ready[grant_idx] = 1'b1;
  end

  assign rr_next = (grant_idx == PW'(N_CH - 1)) ? '0 : grant_idx + PW'(1);
  assign push    = |ready;
  assign pop     = bus.out_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bus.change <= 1'b0;
      bus.on_off <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= rr_next;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        bus.on_off <= mem[rd_ptr];
      end
      bus.change <= pop;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; contents are meaningless until pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.ev_on[grant_idx];
  end

  assign bus.ev_ready   = ready;
  assign bus.fifo_count = count;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
endmodule
